// File: rtl/obj_stream_loader.sv
// Byte-stream loader: packs bytes into DATA_W words and writes (optionally reads back) each one to RAM.
// Latency: word-completing byte at cycle k -> mem_cs_o at k+1; backpressure: byte_ready_o only high in PACK.
module obj_stream_loader #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int BIG_ENDIAN = 1,
    parameter int VERIFY     = 1,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    input  logic              byte_last_i,
    output logic              byte_ready_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_done_i,
    output logic              mem_cs_o,
    output logic              mem_we_o,
    output logic              mem_oe_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [ADDR_W-1:0] err_addr_o,
    output logic [ADDR_W-1:0] word_count_o
);

    localparam int BPW   = DATA_W / 8;
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_PACK, S_WRITE, S_GAP, S_READ, S_FINISH} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  pack_q, pack_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               last_q, last_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               error_q, error_d;
    logic [ADDR_W-1:0]  err_addr_q, err_addr_d;
    logic [ADDR_W-1:0]  wcnt_q, wcnt_d;

    logic [IDX_W-1:0]   lane;
    logic [DATA_W-1:0]  merged;
    logic               xfer;
    logic               word_full;
    logic               tmo_hit;

    // Lane 0 is bits [7:0]; big-endian mirrors the byte index so the first byte lands in the MSB lane.
    assign lane      = (BIG_ENDIAN != 0) ? IDX_W'(BPW - 1) - idx_q : idx_q;
    assign merged    = pack_q | (DATA_W'(byte_data_i) << {lane, 3'b000});
    assign xfer      = (state_q == S_PACK) && byte_valid_i;
    assign word_full = (idx_q == IDX_W'(BPW - 1));
    assign tmo_hit   = !mem_done_i && (tmo_q == TMO_W'(TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        pack_d     = pack_q;
        idx_d      = idx_q;
        last_d     = last_q;
        tmo_d      = tmo_q;
        error_d    = error_q;
        err_addr_d = err_addr_q;
        wcnt_d     = wcnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    addr_d  = base_addr_i;
                    wcnt_d  = '0;
                    error_d = 1'b0;
                    pack_d  = '0;
                    idx_d   = '0;
                    state_d = S_PACK;
                end
            end
            S_PACK: begin
                if (xfer) begin
                    if (word_full || byte_last_i) begin
                        wdata_d = merged;
                        pack_d  = '0;
                        idx_d   = '0;
                        last_d  = byte_last_i;
                        tmo_d   = '0;
                        state_d = S_WRITE;
                    end else begin
                        pack_d = merged;
                        idx_d  = idx_q + IDX_W'(1);
                    end
                end
            end
            S_WRITE: begin
                if (mem_done_i) begin
                    wcnt_d = wcnt_q + ADDR_W'(1);
                    tmo_d  = '0;
                    if (VERIFY != 0) begin
                        state_d = S_GAP;
                    end else if (last_q) begin
                        state_d = S_FINISH;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = S_PACK;
                    end
                end else if (tmo_hit) begin
                    error_d    = 1'b1;
                    err_addr_d = addr_q;
                    state_d    = S_FINISH;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            // Forces chip select low for one cycle between the write and its read-back.
            S_GAP: begin
                tmo_d   = '0;
                state_d = S_READ;
            end
            S_READ: begin
                if (mem_done_i) begin
                    if (mem_rdata_i != wdata_q) begin
                        error_d    = 1'b1;
                        err_addr_d = addr_q;
                        state_d    = S_FINISH;
                    end else if (last_q) begin
                        state_d = S_FINISH;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = S_PACK;
                    end
                end else if (tmo_hit) begin
                    error_d    = 1'b1;
                    err_addr_d = addr_q;
                    state_d    = S_FINISH;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            pack_q     <= '0;
            idx_q      <= '0;
            last_q     <= 1'b0;
            tmo_q      <= '0;
            error_q    <= 1'b0;
            err_addr_q <= '0;
            wcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            pack_q     <= pack_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            tmo_q      <= tmo_d;
            error_q    <= error_d;
            err_addr_q <= err_addr_d;
            wcnt_q     <= wcnt_d;
        end
    end

    assign byte_ready_o = (state_q == S_PACK);
    assign mem_cs_o     = (state_q == S_WRITE) || (state_q == S_READ);
    assign mem_we_o     = (state_q == S_WRITE);
    assign mem_oe_o     = (state_q == S_READ);
    assign busy_o       = (state_q == S_PACK) || (state_q == S_WRITE) ||
                          (state_q == S_GAP)  || (state_q == S_READ);
    assign done_o       = (state_q == S_FINISH);
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign error_o      = error_q;
    assign err_addr_o   = err_addr_q;
    assign word_count_o = wcnt_q;

endmodule
